control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter: WORD_SIZE, 8, instruction width; opcode is [WORD_SIZE-1:WORD_SIZE-4], src is [3:2], dest is [1:0].
REQ-002 Parameter: STATE_SIZE, 4, width of state register and state output.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clr  input  1  reset, synchronous, active-high.
REQ-005 instruction  input  WORD_SIZE  current IR contents.
REQ-006 zero  input  1  ALU zero flag, registered in datapath.
REQ-007 load_R0, load_R1, load_R2, load_R3  output  1 each  register-file load enables.
REQ-008 load_PC, inc_PC  output  1 each  drive program_counter ld_pc/inc_pc.
REQ-009 sel_bus_1_mux  output  3  bus-1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
REQ-010 sel_bus_2_mux  output  2  bus-2 source: 0=ALU, 1=Bus_1, 2=Mem.
REQ-011 load_IR, load_Add_R, load_Reg_Y, load_Reg_Z, write  output  1 each  IR, address-register, ALU-operand, ALU-result loads; memory write strobe.
REQ-012 state  output  STATE_SIZE  current FSM state, for debug.

Function
REQ-013 Opcodes: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8; 9-15 are illegal.
REQ-014 States: S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt.
REQ-015 Outputs are decoded combinationally from state, opcode and zero; every output not listed for a state is 0 and both selects are 0.
REQ-016 S_idle: no asserted outputs; next S_fet1.
REQ-017 S_fet1: sel_bus_1=PC, load_Add_R; next S_fet2.
REQ-018 S_fet2: sel_bus_2=Mem, load_IR, inc_PC; next S_dec.
REQ-019 S_dec, NOP: next S_fet1.
REQ-020 S_dec, ADD/SUB/AND: sel_bus_1=src, load_Reg_Y; next S_ex1.
REQ-021 S_dec, NOT: sel_bus_1=src, load_Reg_Z, sel_bus_2=ALU, load_R[dest]; next S_fet1.
REQ-022 S_dec, RD/WR/BR: sel_bus_1=PC, load_Add_R; next is S_rd1, S_wr1 or S_br1 respectively.
REQ-023 S_dec, BRZ: if zero=1, behaves as BR; if zero=0, inc_PC only (skip operand word), next S_fet1.
REQ-024 S_dec, illegal opcode: no outputs; next S_halt.
REQ-025 S_ex1: sel_bus_1=dest, load_Reg_Z, sel_bus_2=ALU, load_R[dest]; next S_fet1.
REQ-026 S_rd1 and S_wr1: sel_bus_2=Mem, load_Add_R, inc_PC; next S_rd2 or S_wr2 respectively.
REQ-027 S_rd2: sel_bus_2=Mem, load_R[dest]; next S_fet1.
REQ-028 S_wr2: sel_bus_1=src, write; next S_fet1.
REQ-029 S_br1: sel_bus_2=Mem, load_Add_R; next S_br2.
REQ-030 S_br2: sel_bus_2=Mem, load_PC; next S_fet1.
REQ-031 S_halt is absorbing and holds all outputs at 0 until clr.
REQ-032 load_PC and inc_PC are never both 1; at most one load_Rn is 1 per cycle.
REQ-033 Unencoded state values transition to S_halt.
REQ-034 Instruction latency: NOP 3, NOT 3, ALU ops 4, BRZ not-taken 3, RD/WR/BR/BRZ-taken 5 cycles (S_fet1 to the next S_fet1).

Reset
REQ-035 clr=1 at a posedge forces state=S_idle on that edge from any state, including mid-instruction and S_halt.
REQ-036 While state=S_idle all outputs are 0; the first S_fet1 occurs on the cycle after clr deasserts.

Structure
REQ-037 Opcode constants, state encodings and bus-select encodings reside in a shared package, risc_spm_pkg, which the datapath also uses.
REQ-038 The block is a state register plus a next-state/output decoder; no sub-module is needed. An optional op_decode sub-module may hold the combinational decode.

Verification
REQ-039 clr=1 for 2 cycles in S_wr1, then released: state=S_idle with all outputs 0, then S_fet1 on the next cycle.
REQ-040 instruction=8'h1B (ADD src=2, dest=3): S_dec drives sel_bus_1=2 and load_Reg_Y; S_ex1 drives sel_bus_1=3, load_Reg_Z and load_R3; S_fet1 follows.
REQ-041 instruction=8'h80 (BRZ) with zero=0: S_dec asserts inc_PC only, then S_fet1; with zero=1: S_br1 and S_br2 follow, with load_PC=1 in S_br2.
REQ-042 instruction=8'h52 (RD dest=2): state sequence is S_dec, S_rd1, S_rd2, with inc_PC in S_rd1 and load_R2 in S_rd2.
REQ-043 instruction=8'hF0: S_dec goes to S_halt, which stays for 10 cycles with all outputs 0 until clr.
REQ-044 Assertions throughout: never load_PC and inc_PC together, and write=1 only in S_wr2.

Source files
------------

// File: rtl/risc_spm_pkg.sv
// Shared encodings for the RISC SPM: opcodes, control-unit states and bus-select codes.
// Used by both the control unit and the datapath.
package risc_spm_pkg;

  localparam int unsigned OpcodeW = 4;

  typedef enum logic [OpcodeW-1:0] {
    OpNop = 4'd0,
    OpAdd = 4'd1,
    OpSub = 4'd2,
    OpAnd = 4'd3,
    OpNot = 4'd4,
    OpRd  = 4'd5,
    OpWr  = 4'd6,
    OpBr  = 4'd7,
    OpBrz = 4'd8
  } opcode_e;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StFet1 = 4'd1,
    StFet2 = 4'd2,
    StDec  = 4'd3,
    StEx1  = 4'd4,
    StRd1  = 4'd5,
    StRd2  = 4'd6,
    StWr1  = 4'd7,
    StWr2  = 4'd8,
    StBr1  = 4'd9,
    StBr2  = 4'd10,
    StHalt = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    Bus1R0 = 3'd0,
    Bus1R1 = 3'd1,
    Bus1R2 = 3'd2,
    Bus1R3 = 3'd3,
    Bus1Pc = 3'd4
  } bus1_sel_e;

  typedef enum logic [1:0] {
    Bus2Alu  = 2'd0,
    Bus2Bus1 = 2'd1,
    Bus2Mem  = 2'd2
  } bus2_sel_e;

  // One-hot register-file load enable for a 2-bit register index.
  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/control_unit.sv
// RISC SPM control unit: state register plus combinational next-state/output decode
// from state, opcode and the registered ALU zero flag.
module control_unit
  import risc_spm_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 8,
  parameter int unsigned STATE_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [WORD_SIZE-1:0]  instruction,
  input  logic                  zero,
  output logic                  load_R0,
  output logic                  load_R1,
  output logic                  load_R2,
  output logic                  load_R3,
  output logic                  load_PC,
  output logic                  inc_PC,
  output logic [2:0]            sel_bus_1_mux,
  output logic [1:0]            sel_bus_2_mux,
  output logic                  load_IR,
  output logic                  load_Add_R,
  output logic                  load_Reg_Y,
  output logic                  load_Reg_Z,
  output logic                  write,
  output logic [STATE_SIZE-1:0] state
);

  state_e state_q, state_d;

  logic [OpcodeW-1:0] opcode;
  logic [1:0]         src;
  logic [1:0]         dest;
  logic [3:0]         load_r;

  assign opcode = instruction[WORD_SIZE-1 -: OpcodeW];
  assign src    = instruction[3:2];
  assign dest   = instruction[1:0];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    load_r        = 4'b0000;
    load_PC       = 1'b0;
    inc_PC        = 1'b0;
    sel_bus_1_mux = 3'(Bus1R0);
    sel_bus_2_mux = 2'(Bus2Alu);
    load_IR       = 1'b0;
    load_Add_R    = 1'b0;
    load_Reg_Y    = 1'b0;
    load_Reg_Z    = 1'b0;
    write         = 1'b0;

    case (state_q)
      StIdle: state_d = StFet1;
      StFet1: begin
        sel_bus_1_mux = 3'(Bus1Pc);
        load_Add_R    = 1'b1;
        state_d       = StFet2;
      end
      StFet2: begin
        sel_bus_2_mux = 2'(Bus2Mem);
        load_IR       = 1'b1;
        inc_PC        = 1'b1;
        state_d       = StDec;
      end
      StDec: begin
        case (opcode)
          OpNop: state_d = StFet1;
          OpAdd, OpSub, OpAnd: begin
            sel_bus_1_mux = {1'b0, src};
            load_Reg_Y    = 1'b1;
            state_d       = StEx1;
          end
          OpNot: begin
            sel_bus_1_mux = {1'b0, src};
            load_Reg_Z    = 1'b1;
            sel_bus_2_mux = 2'(Bus2Alu);
            load_r        = reg_onehot(dest);
            state_d       = StFet1;
          end
          OpRd, OpWr, OpBr: begin
            sel_bus_1_mux = 3'(Bus1Pc);
            load_Add_R    = 1'b1;
            state_d       = (opcode == OpRd) ? StRd1 :
                            (opcode == OpWr) ? StWr1 : StBr1;
          end
          OpBrz: begin
            if (zero) begin
              sel_bus_1_mux = 3'(Bus1Pc);
              load_Add_R    = 1'b1;
              state_d       = StBr1;
            end else begin
              // Not taken: step the PC over the branch-target word.
              inc_PC  = 1'b1;
              state_d = StFet1;
            end
          end
          default: state_d = StHalt;
        endcase
      end
      StEx1: begin
        sel_bus_1_mux = {1'b0, dest};
        load_Reg_Z    = 1'b1;
        sel_bus_2_mux = 2'(Bus2Alu);
        load_r        = reg_onehot(dest);
        state_d       = StFet1;
      end
      StRd1, StWr1: begin
        sel_bus_2_mux = 2'(Bus2Mem);
        load_Add_R    = 1'b1;
        inc_PC        = 1'b1;
        state_d       = (state_q == StRd1) ? StRd2 : StWr2;
      end
      StRd2: begin
        sel_bus_2_mux = 2'(Bus2Mem);
        load_r        = reg_onehot(dest);
        state_d       = StFet1;
      end
      StWr2: begin
        sel_bus_1_mux = {1'b0, src};
        write         = 1'b1;
        state_d       = StFet1;
      end
      StBr1: begin
        sel_bus_2_mux = 2'(Bus2Mem);
        load_Add_R    = 1'b1;
        state_d       = StBr2;
      end
      StBr2: begin
        sel_bus_2_mux = 2'(Bus2Mem);
        load_PC       = 1'b1;
        state_d       = StFet1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StHalt;
    endcase
  end

  assign {load_R3, load_R2, load_R1, load_R0} = load_r;
  assign state = STATE_SIZE'(state_q);

endmodule
